// File: rtl/shift_reg_sink_pkg.sv
// Shared definitions for shift_reg_sink.
// Provides a constant clog2 helper and legal-range checks for the block
// parameters DEPTH, DWIDTH and FIFO_DEPTH. Imported by every module of the block.
package shift_reg_sink_pkg;

  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 256;

  // Ceiling log2 usable in constant expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

  function automatic bit dwidth_ok(input int dwidth);
    return dwidth >= 1;
  endfunction

  // The buffer must absorb every in-flight beat plus the pop latency, and
  // the pointers rely on natural binary wrap.
  function automatic bit fifo_depth_ok(input int fifo_depth, input int depth);
    return is_pow2(fifo_depth) && (fifo_depth >= depth + 2);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word fall-through FIFO.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data    - push one entry
//   rd_en, rd_data    - pop the head; rd_data shows the head whenever !empty
//   full, empty       - occupancy flags
//   count             - current occupancy, 0..FIFO_DEPTH
module sync_fifo_fwft
  import shift_reg_sink_pkg::*;
#(
  parameter int DWIDTH     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DWIDTH-1:0]                wr_data,
  input  logic                             rd_en,
  output logic [DWIDTH-1:0]                rd_data,
  output logic                             full,
  output logic                             empty,
  output logic [clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = clog2(FIFO_DEPTH + 1);

  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A write to a full FIFO is only accepted together with a pop.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // FIFO_DEPTH is a power of two, so AW-bit pointers wrap modulo FIFO_DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; validity is carried entirely by the
  // pointers, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && full && !do_rd))
        else $error("sync_fifo_fwft: write to full FIFO");
    end
  end

endmodule

// File: rtl/shift_reg_sink.sv
// Fixed-latency delay line feeding a credit-controlled sink FIFO.
// Accepted beats travel DEPTH unconditional shift stages and then land in
// a first-word fall-through buffer. A credit counter (in-flight + buffered
// beats) throttles s_ready so the buffer can never overflow, and s_ready
// depends on registered state only.
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-high reset
//   s_valid, s_data    - upstream beat
//   s_ready            - credit available
//   m_valid, m_data    - head of sink buffer (fall-through)
//   m_ready            - downstream pop
module shift_reg_sink
  import shift_reg_sink_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DWIDTH     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready
);

  localparam int CW = clog2(FIFO_DEPTH + 1);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("shift_reg_sink: DEPTH must be in 1..256");
  end
  if (!dwidth_ok(DWIDTH)) begin : g_bad_dwidth
    $error("shift_reg_sink: DWIDTH must be at least 1");
  end
  if (!fifo_depth_ok(FIFO_DEPTH, DEPTH)) begin : g_bad_fifo_depth
    $error("shift_reg_sink: FIFO_DEPTH must be a power of two >= DEPTH+2");
  end

  logic [DEPTH-1:0]  stage_valid;
  logic [DWIDTH-1:0] stage_data [DEPTH];
  logic [CW-1:0]     credit;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign s_ready = (credit < CW'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // Delay line valid bits: shift every cycle, no stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= accept;
      for (int i = 1; i < DEPTH; i++) stage_valid[i] <= stage_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    stage_data[0] <= s_data;
    for (int i = 1; i < DEPTH; i++) stage_data[i] <= stage_data[i-1];
  end

  // Credit = beats accepted but not yet popped, wherever they are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  sync_fifo_fwft #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (stage_valid[DEPTH-1]),
    .wr_data (stage_data[DEPTH-1]),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Buffered beats are a subset of credited beats; a full buffer means every
  // credit is sitting in it.
  always @(posedge clk) begin
    if (!rst) begin
      assert (fifo_count <= credit)
        else $error("shift_reg_sink: buffer holds more beats than credits");
      assert (!fifo_full || (credit == CW'(FIFO_DEPTH)))
        else $error("shift_reg_sink: full buffer with spare credit");
    end
  end

endmodule

// File: tb/tb_shift_reg_sink.sv
// Self-checking bench for shift_reg_sink (DEPTH=4, FIFO_DEPTH=8, DWIDTH=16).
// Reference model: a queue of accepted beats, each tagged with the edge at
// which it becomes visible (accept edge + DEPTH). Credit is the queue size.
module tb_shift_reg_sink;

  localparam int DEPTH      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int DWIDTH     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DWIDTH-1:0] m_data;
  logic              m_ready;

  logic              f_wr_en;
  logic [DWIDTH-1:0] f_wr_data;
  logic              f_rd_en;
  logic [DWIDTH-1:0] f_rd_data;
  logic              f_full;
  logic              f_empty;
  logic [3:0]        f_count;

  always #5 clk = ~clk;

  shift_reg_sink #(
    .DEPTH      (DEPTH),
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
  );

  // Standalone buffer instance: full + simultaneous pop/write is unreachable
  // through the credit-limited top level.
  sync_fifo_fwft #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_unit (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (f_wr_en),
    .wr_data (f_wr_data),
    .rd_en   (f_rd_en),
    .rd_data (f_rd_data),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_count)
  );

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  logic [DWIDTH-1:0] mdl_data [$];
  int                mdl_vis  [$];

  function automatic logic exp_mvalid();
    return (mdl_vis.size() > 0) && (mdl_vis[0] <= edge_cnt);
  endfunction

  function automatic logic exp_sready();
    return mdl_data.size() < FIFO_DEPTH;
  endfunction

  function automatic logic [DWIDTH-1:0] exp_mdata();
    return (mdl_data.size() > 0) ? mdl_data[0] : '0;
  endfunction

  function automatic void mdl_clear();
    mdl_data.delete();
    mdl_vis.delete();
  endfunction

  // Called at a negedge: drive inputs, advance one edge, update the model,
  // return at the following negedge.
  task automatic tick(input logic sv, input logic [DWIDTH-1:0] sd, input logic mr);
    logic acc;
    logic pp;
    logic [DWIDTH-1:0] dummy_d;
    int dummy_v;
    acc = sv && exp_sready();
    pp  = mr && exp_mvalid();
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(posedge clk);
    edge_cnt++;
    if (pp) begin
      dummy_d = mdl_data.pop_front();
      dummy_v = mdl_vis.pop_front();
    end
    if (acc) begin
      mdl_data.push_back(sd);
      mdl_vis.push_back(edge_cnt + DEPTH);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    f_wr_en = 1'b0; f_wr_data = '0; f_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mvalid_during got=%b want=0", m_valid);
    end
    mdl_clear();
    rst = 1'b0;
    edge_cnt = 0;
    tick(1'b0, '0, 1'b0);
    total++;
    if (s_ready !== 1'b1) begin
      bad++; $display("FAIL reset_sready_after got=%b want=1", s_ready);
    end
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mvalid_after got=%b want=0", m_valid);
    end
  endtask

  task automatic test_single_beat();
    while (edge_cnt < 9) tick(1'b0, '0, 1'b1);
    tick(1'b1, 16'hA5A5, 1'b1);  // accepted at edge 10
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, '0, 1'b1);
      total++;
      if (m_valid !== (edge_cnt == 14)) begin
        bad++; $display("FAIL single_mvalid edge=%0d got=%b want=%b", edge_cnt, m_valid, edge_cnt == 14);
      end
      if (edge_cnt == 14) begin
        total++;
        if (m_data !== 16'hA5A5) begin
          bad++; $display("FAIL single_mdata got=%h want=a5a5", m_data);
        end
      end
    end
  endtask

  task automatic test_stream();
    int got;
    got = 0;
    for (int b = 1; b <= 100 + DEPTH + 4; b++) begin
      if (b <= 100) begin
        total++;
        if (s_ready !== 1'b1) begin
          bad++; $display("FAIL stream_sready beat=%0d got=%b want=1", b, s_ready);
        end
        tick(1'b1, DWIDTH'(b), 1'b1);
      end else begin
        tick(1'b0, '0, 1'b1);
      end
      if (m_valid === 1'b1) begin
        total++;
        if (m_data !== DWIDTH'(got + 1)) begin
          bad++; $display("FAIL stream_order got=%h want=%h", m_data, DWIDTH'(got + 1));
        end
        got++;
      end else if (got > 0 && got < 100) begin
        total++; bad++;
        $display("FAIL stream_gap after=%0d got=m_valid 0 want=1", got);
      end
    end
    total++;
    if (got != 100) begin
      bad++; $display("FAIL stream_count got=%0d want=100", got);
    end
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    int popped;
    logic popped_prev;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (s_ready !== (i < FIFO_DEPTH)) begin
        bad++; $display("FAIL bp_sready cyc=%0d got=%b want=%b", i, s_ready, i < FIFO_DEPTH);
      end
      if (s_ready === 1'b1) acc_cnt++;
      tick(1'b1, DWIDTH'(16'h0100 + acc_cnt - (s_ready ? 1 : 0)), 1'b0);
    end
    total++;
    if (acc_cnt != FIFO_DEPTH) begin
      bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc_cnt, FIFO_DEPTH);
    end
    popped = 0;
    popped_prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_valid === 1'b1) begin
        total++;
        if (m_data !== DWIDTH'(16'h0100 + popped)) begin
          bad++; $display("FAIL bp_order got=%h want=%h", m_data, DWIDTH'(16'h0100 + popped));
        end
      end
      tick(1'b0, '0, 1'b1);
      if (popped == 0 && popped_prev == 1'b0 && mdl_data.size() == FIFO_DEPTH - 1) begin
        total++;
        if (s_ready !== 1'b1) begin
          bad++; $display("FAIL bp_sready_after_pop got=%b want=1", s_ready);
        end
        popped_prev = 1'b1;
      end
      if (FIFO_DEPTH - mdl_data.size() != popped) popped = FIFO_DEPTH - mdl_data.size();
    end
    total++;
    if (popped != FIFO_DEPTH || m_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain got=%0d beats m_valid=%b want=%0d beats m_valid=0", popped, m_valid, FIFO_DEPTH);
    end
  endtask

  task automatic test_full_pop_write();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      f_wr_en = 1'b1; f_wr_data = DWIDTH'(16'h0200 + i); f_rd_en = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (f_full !== 1'b1 || f_count !== 4'd8) begin
      bad++; $display("FAIL full_fill got=full %b count %0d want=full 1 count 8", f_full, f_count);
    end
    f_wr_en = 1'b1; f_wr_data = 16'h02FF; f_rd_en = 1'b1;
    @(posedge clk); @(negedge clk);
    f_wr_en = 1'b0; f_rd_en = 1'b0;
    total++;
    if (f_count !== 4'd8 || f_full !== 1'b1) begin
      bad++; $display("FAIL full_popwrite_count got=%0d want=8", f_count);
    end
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      total++;
      if (f_rd_data !== ((i < FIFO_DEPTH) ? DWIDTH'(16'h0200 + i) : 16'h02FF)) begin
        bad++; $display("FAIL full_drain idx=%0d got=%h want=%h", i, f_rd_data,
                        (i < FIFO_DEPTH) ? DWIDTH'(16'h0200 + i) : 16'h02FF);
      end
      f_rd_en = 1'b1;
      @(posedge clk); @(negedge clk);
      f_rd_en = 1'b0;
    end
    total++;
    if (f_empty !== 1'b1) begin
      bad++; $display("FAIL full_empty_after got=%b want=1", f_empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, DWIDTH'(16'h0300 + i), 1'b0);
    tick(1'b0, '0, 1'b0);
    total++;
    if (m_valid !== 1'b1 || dut.u_fifo.count !== 4'd2) begin
      bad++; $display("FAIL rmid_setup got=m_valid %b count %0d want=m_valid 1 count 2", m_valid, dut.u_fifo.count);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_immediate got=%b want=0", m_valid);
    end
    mdl_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, '0, 1'b1);
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        bad++; $display("FAIL rmid_after cyc=%0d got=m_valid %b s_ready %b want=m_valid 0 s_ready 1", i, m_valid, s_ready);
      end
    end
  endtask

  task automatic test_random();
    int sv_pct;
    int mr_pct;
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 4)
        0:       begin sv_pct = 90; mr_pct = 90; end
        1:       begin sv_pct = 90; mr_pct = 20; end
        2:       begin sv_pct = 30; mr_pct = 80; end
        default: begin sv_pct = 50; mr_pct = 50; end
      endcase
      tick(($urandom % 100) < sv_pct, DWIDTH'($urandom), ($urandom % 100) < mr_pct);
      total++;
      if (m_valid !== exp_mvalid() || s_ready !== exp_sready() ||
          (exp_mvalid() && m_data !== exp_mdata())) begin
        bad++;
        $display("FAIL rand cyc=%0d got=v%b r%b d%h want=v%b r%b d%h", i,
                 m_valid, s_ready, m_data, exp_mvalid(), exp_sready(), exp_mdata());
      end
      total++;
      if (dut.credit > 4'd8) begin
        bad++; $display("FAIL rand_credit cyc=%0d got=%0d want<=8", i, dut.credit);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_stream();
    test_backpressure();
    test_full_pop_write();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
